// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared FSM state encoding and default sizing constants for
//                the wait-state memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Controller states: idle, counting wait states, completion cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH  = 16;
    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_DEPTH       = 4096;
    localparam int DEFAULT_WAIT_STATES = 2;

    // Index width for a power-of-two depth (at least one bit)
    function automatic int index_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port synchronous RAM with write enable and a
//                registered read word. The read register can be cleared on
//                demand and is cleared by reset; array contents never are.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AW         = index_bits(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array write port; storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read register: loads on a read, zeroed by clear or reset, else holds
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (clr) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_ctrl
//  Description : Memory access controller inserting WAIT_STATES extra cycles
//                per request. A request is latched in IDLE or DONE, counted
//                down in WAIT, performed on the last WAIT edge, and flagged by
//                a one-cycle ready pulse.
//                Optional macro MEM_RANGE_CHECK_EN: addresses >= DEPTH are
//                rejected (no write, read returns 0, error with ready).
//                Without it the address wraps modulo DEPTH and error is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  read_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  output_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  error
);

    localparam int         c_addr_bits = index_bits(DEPTH);
    localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);

    state_t                r_state;
    logic [3:0]            r_count;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_error;

    logic                  w_access;
    logic                  w_oor;
    logic                  w_we;
    logic                  w_re;
    logic                  w_clr;
    logic [DATA_WIDTH-1:0] w_read_reg;

    // The access edge is the last WAIT edge; gating with reset keeps an
    // aborted write from reaching the array
    assign w_access = reset && (r_state == ST_WAIT) && (r_count == 4'd0);

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] c_depth_ext = (ADDR_WIDTH+1)'(DEPTH);
    assign w_oor = ({1'b0, r_addr} >= c_depth_ext);
`else
    assign w_oor = 1'b0;
    // Upper address bits are discarded when wrapping modulo DEPTH
    if (c_addr_bits < ADDR_WIDTH) begin : g_unused_hi_addr
        logic w_unused_hi;
        assign w_unused_hi = ^r_addr[ADDR_WIDTH-1:c_addr_bits];
    end
`endif

    assign w_we  = w_access &&  r_wr && !w_oor;
    assign w_re  = w_access && !r_wr && !w_oor;
    assign w_clr = w_access && !r_wr &&  w_oor;

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (c_addr_bits)
    ) u_mem_array (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .re    (w_re),
        .clr   (w_clr),
        .addr  (r_addr[c_addr_bits-1:0]),
        .wdata (r_wdata),
        .rdata (w_read_reg)
    );

    // Request FSM with registered ready/busy/error outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (enable) begin
                        r_wr    <= read_write;
                        r_addr  <= address;
                        r_wdata <= data_in;
                        r_count <= c_wait_init;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_error <= w_oor;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = output_en ? w_read_reg : '0;
    assign ready    = r_ready;
    assign busy     = r_busy;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wait_ctrl
//  Description : Directed bench for mem_wait_ctrl. One instance with two wait
//                states, one with zero wait states for back-to-back traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wait_ctrl;

    logic        clk;
    logic        rst_n;

    logic        en;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] din;
    logic        oe;
    logic [15:0] dout;
    logic        rdy;
    logic        bsy;
    logic        err;

    logic        en0;
    logic        rw0;
    logic [15:0] addr0;
    logic [15:0] din0;
    logic [15:0] dout0;
    logic        rdy0;
    logic        bsy0;
    logic        err0;

    int n_vec;
    int n_err;

    mem_wait_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .DEPTH      (4096),
        .WAIT_STATES(2)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .enable     (en),
        .read_write (rw),
        .address    (addr),
        .data_in    (din),
        .output_en  (oe),
        .data_out   (dout),
        .ready      (rdy),
        .busy       (bsy),
        .error      (err)
    );

    mem_wait_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .DEPTH      (4096),
        .WAIT_STATES(0)
    ) dut0 (
        .clk        (clk),
        .reset      (rst_n),
        .enable     (en0),
        .read_write (rw0),
        .address    (addr0),
        .data_in    (din0),
        .output_en  (1'b1),
        .data_out   (dout0),
        .ready      (rdy0),
        .busy       (bsy0),
        .error      (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on the two-wait-state instance. Checks busy/ready timing,
    // returns error and data_out seen in the ready cycle. With poke set,
    // enable is raised for exactly one WAIT edge and must be ignored.
    task automatic do_req(input string tag, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input bit poke,
                          output logic e_seen, output logic [15:0] d_seen);
        en = 1'b1; rw = wr; addr = a; din = d;
        @(posedge clk); #1;                      // accept edge T
        en = 1'b0;
        chk({tag, "_busy_t0"}, 32'(bsy), 32'd1);
        chk({tag, "_rdy_t0"},  32'(rdy), 32'd0);
        @(posedge clk); #1;                      // T+1
        chk({tag, "_busy_t1"}, 32'(bsy), 32'd1);
        if (poke) begin
            en = 1'b1; rw = 1'b1; addr = 16'h0011; din = 16'hDEAD;
        end
        @(posedge clk); #1;                      // T+2
        en = 1'b0;
        chk({tag, "_busy_t2"}, 32'(bsy), 32'd1);
        chk({tag, "_rdy_t2"},  32'(rdy), 32'd0);
        @(posedge clk); #1;                      // T+3: completion
        chk({tag, "_rdy_t3"},  32'(rdy), 32'd1);
        chk({tag, "_busy_t3"}, 32'(bsy), 32'd0);
        e_seen = err;
        d_seen = dout;
        @(posedge clk); #1;                      // T+4: back to idle
        chk({tag, "_rdy_t4"},  32'(rdy), 32'd0);
        chk({tag, "_err_t4"},  32'(err), 32'd0);
    endtask

    logic        e_s;
    logic [15:0] d_s;
    int          rdy_cnt;

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        en = 1'b0; rw = 1'b0; addr = '0; din = '0; oe = 1'b1;
        en0 = 1'b0; rw0 = 1'b0; addr0 = '0; din0 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy),  32'd0);
        chk("rst_busy",  32'(bsy),  32'd0);
        chk("rst_error", 32'(err),  32'd0);
        chk("rst_dout",  32'(dout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 0xBEEF to 0x0010, then read it back
        do_req("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 1'b0, e_s, d_s);
        chk("wr_beef_err", 32'(e_s), 32'd0);
        do_req("rd_beef", 1'b0, 16'h0010, 16'h0000, 1'b0, e_s, d_s);
        chk("rd_beef_err",  32'(e_s), 32'd0);
        chk("rd_beef_data", 32'(d_s), 32'h0000BEEF);
        oe = 1'b0; #1;
        chk("oe_low_dout", 32'(dout), 32'd0);
        oe = 1'b1; #1;
        chk("oe_high_hold", 32'(dout), 32'h0000BEEF);

        // A write must leave the read register untouched
        do_req("wr_1111", 1'b1, 16'h0010, 16'h1111, 1'b0, e_s, d_s);
        chk("wr_keeps_rreg", 32'(dout), 32'h0000BEEF);
        do_req("rd_1111", 1'b0, 16'h0010, 16'h0000, 1'b0, e_s, d_s);
        chk("rd_1111_data", 32'(d_s), 32'h00001111);

        // Reset in the second WAIT cycle aborts a pending write
        do_req("wr_cafe", 1'b1, 16'h0020, 16'hCAFE, 1'b0, e_s, d_s);
        en = 1'b1; rw = 1'b1; addr = 16'h0020; din = 16'h1234;
        @(posedge clk); #1;                      // accept edge T
        en = 1'b0;
        @(posedge clk); #1;                      // T+1
        rst_n = 1'b0;
        @(posedge clk); #1;                      // T+2 under reset
        chk("abort_busy",  32'(bsy),  32'd0);
        chk("abort_ready", 32'(rdy),  32'd0);
        chk("abort_rreg",  32'(dout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_cnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdy) rdy_cnt++;
        end
        chk("abort_no_ready", 32'(rdy_cnt), 32'd0);
        do_req("rd_cafe", 1'b0, 16'h0020, 16'h0000, 1'b0, e_s, d_s);
        chk("rd_cafe_data", 32'(d_s), 32'h0000CAFE);

`ifdef MEM_RANGE_CHECK_EN
        do_req("wr_0777", 1'b1, 16'h0005, 16'h0777, 1'b0, e_s, d_s);
        do_req("rd_oor", 1'b0, 16'h1000, 16'h0000, 1'b0, e_s, d_s);
        chk("rd_oor_err",  32'(e_s), 32'd1);
        chk("rd_oor_data", 32'(d_s), 32'd0);
        do_req("wr_oor", 1'b1, 16'h1005, 16'h5A5A, 1'b0, e_s, d_s);
        chk("wr_oor_err", 32'(e_s), 32'd1);
        do_req("rd_0005", 1'b0, 16'h0005, 16'h0000, 1'b0, e_s, d_s);
        chk("rd_0005_err",  32'(e_s), 32'd0);
        chk("rd_0005_data", 32'(d_s), 32'h00000777);
`else
        do_req("wr_alias", 1'b1, 16'h1005, 16'h5A5A, 1'b0, e_s, d_s);
        chk("wr_alias_err", 32'(e_s), 32'd0);
        do_req("rd_alias", 1'b0, 16'h0005, 16'h0000, 1'b0, e_s, d_s);
        chk("rd_alias_err",  32'(e_s), 32'd0);
        chk("rd_alias_data", 32'(d_s), 32'h00005A5A);
`endif

        // Enable pulsed during WAIT is ignored: no extra request, no write
        do_req("poke", 1'b1, 16'h0030, 16'h4321, 1'b1, e_s, d_s);
        rdy_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy || bsy) rdy_cnt++;
        end
        chk("poke_no_extra", 32'(rdy_cnt), 32'd0);
        do_req("rd_0011", 1'b0, 16'h0011, 16'h0000, 1'b0, e_s, d_s);
        chk("poke_not_written", 32'(d_s == 16'hDEAD), 32'd0);
        do_req("rd_0030", 1'b0, 16'h0030, 16'h0000, 1'b0, e_s, d_s);
        chk("rd_0030_data", 32'(d_s), 32'h00004321);

        // Zero wait states, enable held: one completion every second cycle
        begin
            logic        v_wr [6];
            logic [15:0] v_a  [6];
            logic [15:0] v_d  [6];
            v_wr[0] = 1'b1; v_a[0] = 16'h0040; v_d[0] = 16'h1357;
            v_wr[1] = 1'b0; v_a[1] = 16'h0040; v_d[1] = 16'h1357;
            v_wr[2] = 1'b1; v_a[2] = 16'h0041; v_d[2] = 16'h2468;
            v_wr[3] = 1'b0; v_a[3] = 16'h0041; v_d[3] = 16'h2468;
            v_wr[4] = 1'b1; v_a[4] = 16'h0040; v_d[4] = 16'h9ABC;
            v_wr[5] = 1'b0; v_a[5] = 16'h0040; v_d[5] = 16'h9ABC;
            en0 = 1'b1; rw0 = v_wr[0]; addr0 = v_a[0]; din0 = v_d[0];
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;              // accept
                chk($sformatf("b2b%0d_busy", i), 32'(bsy0), 32'd1);
                chk($sformatf("b2b%0d_rdy0", i), 32'(rdy0), 32'd0);
                @(posedge clk); #1;              // access
                chk($sformatf("b2b%0d_rdy1", i), 32'(rdy0), 32'd1);
                if (!v_wr[i]) begin
                    chk($sformatf("b2b%0d_data", i), 32'(dout0), 32'(v_d[i]));
                end
                if (i < 5) begin
                    rw0 = v_wr[i+1]; addr0 = v_a[i+1]; din0 = v_d[i+1];
                end
            end
            en0 = 1'b0;
            @(posedge clk); #1;
            chk("b2b_end_rdy", 32'(rdy0), 32'd0);
            chk("b2b_end_err", 32'(err0), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
